// File: rtl/imem_loader.sv
// imem_loader
// Serial program loader feeding the instruction memory write port. It takes a
// framed byte stream (LEN_LO, LEN_HI, 4N payload bytes LSB-first, CSUM) over
// a valid/ready handshake. It assembles little-endian 32-bit words and writes
// them to consecutive word addresses starting at 0. The CPU is held until a
// frame has loaded and its checksum matches.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start             begins a load (honoured only in IDLE, DONE or ERR)
//   in_valid/in_data  byte stream in; in_ready is the registered accept flag
//   imem_we           one-cycle write strobe per assembled word
//   imem_waddr/wdata  word-aligned byte address and data, held between writes
//   cpu_hold          CPU reset/stall request, low only in DONE
//   done, error       sticky load outcome flags
//   words_loaded      words written in the current frame
//
// state  | meaning
// -------+-----------------------------------------------------
// IDLE   | after reset, waiting for start
// LEN_LO | waiting for the low byte of the word count
// LEN_HI | waiting for the high byte; the length is checked here
// DATA   | receiving payload bytes, one write per 4 bytes
// CSUM   | waiting for the checksum byte
// DONE   | image loaded and verified; CPU released
// ERR    | bad length or checksum; CPU kept in hold
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [8:0]        words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t            state, next_state;
    logic [7:0]        len_lo;
    logic [15:0]       words_left;
    logic [1:0]        byte_idx;
    logic [23:0]       word_buf;
    logic [7:0]        csum;
    logic [ADDR_W-1:0] addr;

    logic        accept;
    logic [15:0] len_full;
    logic        len_bad;

    assign accept   = in_valid & in_ready;
    assign len_full = {in_data, len_lo};
    assign len_bad  = (len_full == 16'd0) || ({1'b0, len_full} > DEPTH_L);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_ERR:
                if (start) next_state = S_LEN_LO;
            S_LEN_LO:
                if (accept) next_state = S_LEN_HI;
            S_LEN_HI:
                if (accept) next_state = len_bad ? S_ERR : S_DATA;
            S_DATA:
                // words_left is a down-counter; terminal count is the last word
                if (accept && byte_idx == 2'd3 && words_left == 16'd1)
                    next_state = S_CSUM;
            S_CSUM:
                if (accept) next_state = (in_data == csum) ? S_DONE : S_ERR;
            default:
                next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_waddr   <= '0;
            imem_wdata   <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            len_lo       <= '0;
            words_left   <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
            csum         <= '0;
            addr         <= '0;
        end else begin
            // Flags are decoded from next_state so they line up with the state register.
            in_ready <= (next_state == S_LEN_LO) || (next_state == S_LEN_HI) ||
                        (next_state == S_DATA)   || (next_state == S_CSUM);
            cpu_hold <= (next_state != S_DONE);
            imem_we  <= 1'b0;

            // Counts the write strobe issued on the previous edge.
            if (imem_we) words_loaded <= words_loaded + 9'd1;

            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        csum         <= '0;
                        byte_idx     <= '0;
                        addr         <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (accept) len_lo <= in_data;
                end
                S_LEN_HI: begin
                    if (accept) begin
                        words_left <= len_full;
                        if (len_bad) error <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        csum     <= csum + in_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0:    word_buf[7:0]   <= in_data;
                            2'd1:    word_buf[15:8]  <= in_data;
                            2'd2:    word_buf[23:16] <= in_data;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_wdata <= {in_data, word_buf};
                                imem_waddr <= addr;
                                addr       <= addr + ADDR_W'(4);
                                words_left <= words_left - 16'd1;
                            end
                        endcase
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        if (in_data == csum) done  <= 1'b1;
                        else                 error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Self-checking bench for imem_loader: a table of whole-frame vectors
// (length, checksum offset, gap/start noise, expected outcome) plus
// hand-written sequences for reset-mid-frame and reload. A negedge monitor
// checks every write against the expected word image and address 4*k, and
// checks that address/data hold between writes.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, imem_we, cpu_hold, done, error;
    logic [31:0] imem_waddr, imem_wdata;
    logic [8:0]  words_loaded;

    imem_loader #(.DEPTH(256), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
        .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          wr_count = 0;
    logic [31:0] exp_words [256];
    logic [31:0] last_a = 0, last_d = 0;
    logic        saw_rst = 1'b1;

    typedef struct {
        int   len;
        int   adj;
        int   gap;
        bit   st;
        bit   exp_done;
        bit   exp_err;
        int   exp_writes;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) saw_rst <= rst;

    always @(negedge clk) begin
        if (saw_rst) begin
            last_a = 0;
            last_d = 0;
        end else if (imem_we) begin
            chk("waddr", imem_waddr, 32'(4 * wr_count));
            chk("wdata", imem_wdata, exp_words[8'(wr_count)]);
            last_a = imem_waddr;
            last_d = imem_wdata;
            wr_count++;
        end else begin
            chk("waddr_hold", imem_waddr, last_a);
            chk("wdata_hold", imem_wdata, last_d);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap, input bit st);
        int k;
        int g;
        g = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
        repeat (g) begin
            @(negedge clk);
            in_valid = 1'b0;
            start    = st;
        end
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k == 50) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // A byte presented alongside start must not be taken as LEN_LO.
    task automatic do_start();
        wr_count = 0;
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic send_body(input int len, input int adj, input int gap, input bit st);
        logic [7:0] sum;
        sum = 8'h00;
        send_byte(len[7:0], gap, st);
        send_byte(len[15:8], gap, st);
        if (len >= 1 && len <= 256) begin
            for (int k = 0; k < len; k++)
                for (int b = 0; b < 4; b++) begin
                    sum = sum + exp_words[k][8*b +: 8];
                    send_byte(exp_words[k][8*b +: 8], gap, st);
                end
            send_byte(sum + 8'(adj), gap, st);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_end(input string nm, input bit d, input bit e, input int w);
        chk({nm, "_done"},     32'(done), 32'(d));
        chk({nm, "_error"},    32'(error), 32'(e));
        chk({nm, "_cpu_hold"}, 32'(cpu_hold), 32'(!d));
        chk({nm, "_words"},    32'(words_loaded), 32'(w));
        chk({nm, "_writes"},   32'(wr_count), 32'(w));
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({nm, "_we"},       32'(imem_we), 32'd0);
        chk({nm, "_waddr"},    imem_waddr, 32'd0);
        chk({nm, "_wdata"},    imem_wdata, 32'd0);
        chk({nm, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        chk({nm, "_done"},     32'(done), 32'd0);
        chk({nm, "_error"},    32'(error), 32'd0);
        chk({nm, "_words"},    32'(words_loaded), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;

        exp_words[0] = 32'h0000_0013;
        exp_words[1] = 32'h0010_0093;
        for (int k = 2; k < 256; k++)
            exp_words[k] = {8'(k) ^ 8'h5A, 8'(k * 3), 8'(k + 1), 8'(k)};

        //          len  adj   gap st  done err writes
        vecs[0] = '{2,   0,    0,  0,  1,   0,  2};
        vecs[1] = '{2,   2,    0,  0,  0,   1,  2};
        vecs[2] = '{0,   0,    0,  0,  0,   1,  0};
        vecs[3] = '{257, 0,    0,  0,  0,   1,  0};
        vecs[4] = '{256, 0,    0,  0,  1,   0,  256};
        vecs[5] = '{2,   0,    3,  1,  1,   0,  2};
        vecs[6] = '{1,   0,    2,  1,  1,   0,  1};
        vecs[7] = '{3,   255,  0,  0,  0,   1,  3};

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_start();
            send_body(vecs[i].len, vecs[i].adj, vecs[i].gap, vecs[i].st);
            chk_end($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_err,
                    vecs[i].exp_writes);
            if (vecs[i].len == 256) chk("last_addr", last_a, 32'h0000_03FC);
        end

        // Reset after 6 payload bytes of a 2-word frame.
        do_start();
        send_byte(8'h02, 0, 0);
        send_byte(8'h00, 0, 0);
        for (int j = 0; j < 6; j++)
            send_byte(exp_words[j / 4][8*(j % 4) +: 8], 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_writes", 32'(wr_count), 32'd1);
        chk_reset_vals("midrst");

        do_start();
        send_body(2, 0, 0, 0);
        chk_end("after_rst", 1'b1, 1'b0, 2);

        // Reload from DONE: flags drop on the start edge, then overwrite from 0.
        wr_count = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("reload_done",     32'(done), 32'd0);
        chk("reload_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("reload_in_ready", 32'(in_ready), 32'd1);
        send_body(3, 0, 1, 0);
        chk_end("reload", 1'b1, 1'b0, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
